// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the FFT output path: frame size,
//                complex sample type, 9-bit bit-reversal helper and the
//                reorder-buffer read FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int N_FFT   = 512;
    localparam int LOG2_N  = 9;
    localparam int CPLX_DW = 16;

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_STREAM   = 2'd2
    } rob_state_e;

    function automatic logic [LOG2_N-1:0] bitrev9(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rob_bank_ram
//  Description : One bank of the reorder buffer. Single clock, one write
//                port and one read port, registered read data (one cycle
//                latency from re to rdata). Contents are not reset.
//  Ports       : clk          clock
//                we/waddr/wdata  write port
//                re/raddr     read request, rdata valid the next cycle
//                rdata        registered read data (held when re is low)
//  Revision    : 1.0  initial release
// ============================================================================
module rob_bank_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = N_FFT,
    parameter int AW    = LOG2_N,
    parameter int WIDTH = $bits(cplx_t)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fft_out_reorder_buf
//  Description : Ping-pong 512-point output reorder memory. CBFP2 samples are
//                written at bit-reversed addresses into the write bank; on a
//                full_512 pulse (read side idle) the banks swap and the
//                finished frame streams out in natural order over valid/ready.
//  Ports       : clk, rstn (async, active-low)
//                in_valid/in_re/in_im   input samples, no backpressure
//                full_512               end-of-frame pulse
//                out_valid/out_ready    output handshake
//                out_re/out_im/out_idx/out_last  natural-order sample
//                ovf, len_err           sticky error flags
//  Options     : FFT_REORDER_ERR_EN - implements ovf/len_err; when undefined
//                both flags are tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_out_reorder_buf
    import fft_pkg::*;
#(
    parameter int DW = 16,
    parameter int N  = N_FFT,
    parameter int AW = LOG2_N
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          full_512,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          ovf,
    output logic          len_err
);

    // ---------------- state ----------------
    logic          wr_bank_q,   wr_bank_d;
    logic [AW-1:0] wr_cnt_q,    wr_cnt_d;
    rob_state_e    state_q,     state_d;
    logic [AW-1:0] rd_addr_q,   rd_addr_d;
    logic          rd_done_q,   rd_done_d;     // all N reads issued
    logic          ram_vld_q,   ram_vld_d;     // RAM output holds a fresh read
    logic [AW-1:0] ram_idx_q,   ram_idx_d;     // index of that read
    logic          skid_vld_q,  skid_vld_d;
    cplx_t         skid_data_q, skid_data_d;
    logic [AW-1:0] skid_idx_q,  skid_idx_d;
    logic          out_valid_q, out_valid_d;
    cplx_t         out_data_q,  out_data_d;
    logic [AW-1:0] out_idx_q,   out_idx_d;
    logic          out_last_q,  out_last_d;

    // ---------------- combinational ----------------
    logic          swap_ok;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt_inc;
    cplx_t         wr_data;
    cplx_t         ram_rdata;
    logic [2*DW-1:0] bank_rdata [2];
    logic          pop;
    logic [1:0]    occ;
    logic          issue;

    assign swap_ok    = full_512 && (state_q == ST_IDLE);
    assign rd_bank    = ~wr_bank_q;
    assign wr_cnt_inc = wr_cnt_q + AW'(in_valid);
    assign wr_data.re = in_re;
    assign wr_data.im = in_im;
    assign ram_rdata  = bank_rdata[rd_bank];
    assign pop        = out_valid_q && out_ready;

    // Entries in flight: output register, holding register and the read
    // currently in the RAM pipe. A new read is issued only if its data is
    // guaranteed a slot, so at most two entries ever coexist.
    assign occ   = {1'b0, out_valid_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
    assign issue = ((state_q == ST_PREFETCH) || (state_q == ST_STREAM)) && !rd_done_q
                   && ((occ - {1'b0, pop}) < 2'd2);

    // ---------------- banks ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        rob_bank_ram #(
            .DEPTH (N),
            .AW    (AW),
            .WIDTH (2*DW)
        ) u_ram (
            .clk   (clk),
            .we    (in_valid && (wr_bank_q == 1'(b))),
            .waddr (bitrev9(wr_cnt_q)),
            .wdata (wr_data),
            .re    (issue && (rd_bank == 1'(b))),
            .raddr (rd_addr_q),
            .rdata (bank_rdata[b])
        );
    end

    // ---------------- write side ----------------
    always_comb begin
        wr_bank_d = wr_bank_q ^ swap_ok;
        // A full_512 clear wins over a same-cycle write increment.
        wr_cnt_d  = full_512 ? '0 : wr_cnt_inc;
    end

    // ---------------- read FSM ----------------
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_done_d = rd_done_q;
        case (state_q)
            ST_IDLE: begin
                if (swap_ok) begin
                    state_d   = ST_PREFETCH;
                    rd_addr_d = '0;
                    rd_done_d = 1'b0;
                end
            end
            ST_PREFETCH: state_d = ST_STREAM;
            ST_STREAM: begin
                if (pop && out_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == AW'(N-1)) begin
                rd_done_d = 1'b1;
            end
        end
    end

    // ---------------- output / holding register ----------------
    always_comb begin
        ram_vld_d   = issue;
        ram_idx_d   = issue ? rd_addr_q : ram_idx_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_idx_d  = skid_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (!out_valid_q || pop) begin
            // Output slot frees: oldest entry (holding reg) goes first.
            if (skid_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_idx_d   = skid_idx_q;
                out_last_d  = (skid_idx_q == AW'(N-1));
                skid_vld_d  = ram_vld_q;
                skid_data_d = ram_rdata;
                skid_idx_d  = ram_idx_q;
            end else if (ram_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_rdata;
                out_idx_d   = ram_idx_q;
                out_last_d  = (ram_idx_q == AW'(N-1));
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (ram_vld_q) begin
            // Stalled: park the read that was already in flight.
            skid_vld_d  = 1'b1;
            skid_data_d = ram_rdata;
            skid_idx_d  = ram_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_idx_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_done_q   <= rd_done_d;
            ram_vld_q   <= ram_vld_d;
            ram_idx_q   <= ram_idx_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_idx_q  <= skid_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_data_q.re;
    assign out_im    = out_data_q.im;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

    // ---------------- error flags ----------------
`ifdef FFT_REORDER_ERR_EN
    logic wrap_q,    wrap_d;
    logic ovf_q,     ovf_d;
    logic len_err_q, len_err_d;
    logic wrap_eff;

    always_comb begin
        // Count the same-cycle sample so a pulse coinciding with the Nth
        // write still reads as an exact frame.
        wrap_eff  = wrap_q | (in_valid && (wr_cnt_q == AW'(N-1)));
        wrap_d    = full_512 ? 1'b0 : wrap_eff;
        ovf_d     = ovf_q | (full_512 && (state_q != ST_IDLE));
        len_err_d = len_err_q | (full_512 && !((wr_cnt_inc == '0) && wrap_eff));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_d;
            len_err_q <= len_err_d;
        end
    end

    assign ovf     = ovf_q;
    assign len_err = len_err_q;
`else
    assign ovf     = 1'b0;
    assign len_err = 1'b0;
`endif

endmodule
`default_nettype wire
